// File: rtl/execute_alu.sv
// Execute-stage ALU: single-cycle integer ops plus a multi-cycle MUL
// sequenced by an IDLE/BUSY/DONE FSM with kill and async reset.
module execute_alu #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LOAD_CNT = 4'(MUL_LATENCY - 1);
  localparam logic [3:0] OP_MUL   = 4'd9;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_a, r_b, r_product;
  logic [31:0] w_alu, w_mul_a, w_mul_b, w_mul;
  logic        w_accept, w_load_product, w_clear_product;

  assign w_accept = (r_state == IDLE) && start && (op == OP_MUL) && !kill;

  // With MUL_LATENCY=2 the product is captured straight from the inputs at acceptance
  assign w_mul_a = (r_state == IDLE) ? src_a : r_a;
  assign w_mul_b = (r_state == IDLE) ? src_b : r_b;
  assign w_mul   = w_mul_a * w_mul_b;

  always_comb begin
    w_alu = 32'd0;
    case (op)
      4'd0:    w_alu = src_a + src_b;
      4'd1:    w_alu = src_a - src_b;
      4'd2:    w_alu = src_a & src_b;
      4'd3:    w_alu = src_a | src_b;
      4'd4:    w_alu = src_a ^ src_b;
      4'd5:    w_alu = {31'd0, ($signed(src_a) < $signed(src_b))};
      4'd6:    w_alu = src_a << src_b[4:0];
      4'd7:    w_alu = src_a >> src_b[4:0];
      4'd8:    w_alu = 32'($signed(src_a) >>> src_b[4:0]);
      default: w_alu = 32'd0;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    w_load_product  = 1'b0;
    w_clear_product = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_next = LOAD_CNT;
          if (LOAD_CNT == 4'd1) begin
            w_next         = DONE;
            w_load_product = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (kill) begin
          w_next          = IDLE;
          w_cnt_next      = 4'd0;
          w_clear_product = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd2) begin
            w_next         = DONE;
            w_load_product = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end
      end
      DONE: begin
        w_next          = IDLE;
        w_cnt_next      = 4'd0;
        w_clear_product = kill;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_product <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_a <= src_a;
        r_b <= src_b;
      end
      if (w_load_product) begin
        r_product <= w_mul;
      end else if (w_clear_product) begin
        r_product <= 32'd0;
      end
    end
  end

  // Reset overrides the combinational result path so outputs settle without a clock
  always_comb begin
    result = w_alu;
    ready  = 1'b1;
    busy   = 1'b0;
    if (reset) begin
      result = 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          ready = !w_accept;
        end
        BUSY: begin
          busy   = 1'b1;
          ready  = kill;
          result = 32'd0;
        end
        DONE: begin
          result = kill ? 32'd0 : r_product;
        end
        default: begin
          result = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_alu.sv
// Self-checking bench for execute_alu: directed spec vectors plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_execute_alu;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: age of the in-flight MUL (0 = none) and its expected product
  int          m_age = 0;
  logic [31:0] m_prod = 32'd0;
  logic        cmp_accept;

  execute_alu #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
    .src_a(src_a), .src_b(src_b), .result(result), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: begin
        ext = {{32{a[31]}}, a} >> b[4:0];
        return ext[31:0];
      end
      4'd9: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model advance on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_age <= 0;
    end else if (m_age == 0) begin
      if (start && op == 4'd9 && !kill) begin
        m_age  <= 1;
        m_prod <= ref_alu(4'd9, src_a, src_b);
      end
    end else if (kill || m_age == L - 1) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
    end else if (m_age == 0) begin
      cmp_accept = start && op == 4'd9 && !kill;
      check("idle_ready", {31'd0, ready}, {31'd0, !cmp_accept});
      check("idle_busy", {31'd0, busy}, 32'd0);
      if (!cmp_accept && op != 4'd9) check("idle_result", result, ref_alu(op, src_a, src_b));
    end else if (m_age < L - 1) begin
      check("busy_busy", {31'd0, busy}, 32'd1);
      check("busy_ready", {31'd0, ready}, {31'd0, kill});
    end else begin
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_ready", {31'd0, ready}, 32'd1);
      if (!kill) check("done_result", result, m_prod);
    end
  end

  task automatic cyc(input logic st, input logic k, input logic [3:0] o,
                     input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = st; kill = k; op = o; src_a = a; src_b = b;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD wrap, SLT, SRA with same-cycle ready
    cyc(1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd2);
    #3 check("add_wrap", result, 32'h0000_0001);
    check("add_ready", {31'd0, ready}, 32'd1);
    cyc(1'b1, 1'b0, 4'd5, 32'hFFFF_FFFE, 32'd1);
    #3 check("slt_neg", result, 32'd1);
    cyc(1'b1, 1'b0, 4'd8, 32'h8000_0000, 32'd4);
    #3 check("sra", result, 32'hF800_0000);
    cyc(1'b1, 1'b0, 4'd12, 32'h1234_5678, 32'h9);
    #3 check("reserved", result, 32'd0);

    // MUL latency with operands dropped after acceptance
    cyc(1'b1, 1'b0, 4'd9, 32'h0001_0000, 32'h0003_0001);
    #3 check("mul_c0_ready", {31'd0, ready}, 32'd0);
    cyc(1'b0, 1'b0, 4'd9, 32'd0, 32'd0);
    #3 check("mul_c1_ready", {31'd0, ready}, 32'd0);
    cyc(1'b0, 1'b0, 4'd9, 32'd0, 32'd0);
    #3 check("mul_c2_ready", {31'd0, ready}, 32'd0);
    cyc(1'b0, 1'b0, 4'd9, 32'd0, 32'd0);
    #3 check("mul_c3_ready", {31'd0, ready}, 32'd1);
    check("mul_c3_result", result, 32'h0001_0000);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #3 check("mul_c4_busy", {31'd0, busy}, 32'd0);
    check("mul_c4_ready", {31'd0, ready}, 32'd1);

    // Kill during BUSY discards 7*6
    cyc(1'b1, 1'b0, 4'd9, 32'd7, 32'd6);
    cyc(1'b0, 1'b1, 4'd9, 32'd7, 32'd6);
    #3 check("kill_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 4'd9, 32'd7, 32'd6);
      #3 check("kill_no42", {31'd0, (ready && result == 32'd42)}, 32'd0);
      check("kill_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Kill together with a MUL start starts nothing
    cyc(1'b1, 1'b1, 4'd9, 32'd3, 32'd3);
    #3 check("kill_start_ready", {31'd0, ready}, 32'd1);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #3 check("kill_start_busy", {31'd0, busy}, 32'd0);

    // Async reset in the middle of BUSY
    cyc(1'b1, 1'b0, 4'd9, 32'd11, 32'd13);
    cyc(1'b0, 1'b0, 4'd9, 32'd11, 32'd13);
    #2 reset = 1'b1;
    #1 check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b1; kill = 1'b0; op = 4'd0; src_a = 32'd3; src_b = 32'd4;
    #3 check("post_rst_add", result, 32'd7);

    // Back-to-back MULs
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'd9, 32'd2, 32'd3);
    #3 check("b2b_first_ready", {31'd0, ready}, 32'd1);
    check("b2b_first_result", result, 32'd6);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 4'd9, 32'd5, 32'd5);
      if (i == 0) begin
        #3 check("b2b_second_accept", {31'd0, ready}, 32'd0);
      end
    end
    #3 check("b2b_second_ready", {31'd0, ready}, 32'd1);
    check("b2b_second_result", result, 32'd25);

    // Random traffic checked by the every-cycle compare
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ro;
      ro = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ro, $urandom, $urandom);
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      else reset = 1'b0;
    end
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
